// File: rtl/simon_pkt_sched.sv
// simon_pkt_sched: packet scheduler between the host byte-packet interface
// and the SIMON round core.
//
// Host packets are captured into a DEPTH-slot input queue. They are issued
// to the core one at a time and in order. Core results are collected into a
// DEPTH-slot output queue and handed back through the donePKT/readPKT handshake.
//
// Packet byte map, for PB = N/2+2 bytes:
//   [PB-1] info, [PB-2] count, [PB-3:N/4] block 1, [N/4-1:0] block 0.
// Info byte fields:
//   bit5 = key packet
//   bit6 = encrypt / decrypt
//   bit7 = error flag (output only)
//
// Optional feature: define SIMON_PKT_SEQCHK_EN to enable count-byte sequence
// checking. A data packet whose count does not match the expected count
// bypasses the core and is returned with info bit7 set and zero blocks.
module simon_pkt_sched #(
  parameter  int N     = 16,
  parameter  int DEPTH = 4,
  localparam int PB    = N / 2 + 2,
  localparam int PW    = PB * 8,
  localparam int RW    = 4 * N,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nR,
  input  logic          in_newPKT,
  input  logic [PW-1:0] in,
  output logic          in_loadPKT,
  output logic          in_donePKT,
  output logic          out_donePKT,
  output logic [PW-1:0] out,
  input  logic          out_readPKT,
  output logic          core_go,
  output logic [PW-1:0] core_pkt,
  input  logic          core_done,
  input  logic [RW-1:0] core_res
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // queue storage (data only, never reset)
  logic [PW-1:0] imem [DEPTH];
  logic [PW-1:0] omem [DEPTH];

  // queue pointers: one extra wrap bit distinguishes full from empty
  logic [AW:0] iw_q, iw_d, ir_q, ir_d;
  logic [AW:0] ow_q, ow_d, or_q, or_d;

  logic arm_q, arm_d;        // capture armed once in_newPKT seen low
  logic load_q, load_d;      // in_loadPKT pulse
  logic lock_q, lock_d;      // output read lock
  logic rdp_q, rdp_d;        // previous out_readPKT sample

  logic [PW-1:0] core_pkt_q, core_pkt_d;
  logic [RW-1:0] res_q, res_d;

  logic          in_full, in_empty, out_full, out_empty;
  logic          in_push, out_push, out_pop;
  logic          issue_ok, seq_err;
  logic [PW-1:0] head, out_word;
  logic [7:0]    head_info, head_cnt, pkt_info, pkt_cnt;
  logic [RW-1:0] wr_blk;
  logic [AW:0]   out_occ;
  logic [AW+1:0] credits;

  function automatic logic q_full(input logic [AW:0] w, input logic [AW:0] r);
    return (w[AW] != r[AW]) && (w[AW-1:0] == r[AW-1:0]);
  endfunction

  function automatic logic q_empty(input logic [AW:0] w, input logic [AW:0] r);
    return w == r;
  endfunction

  // queue status, head decode and output-credit accounting
  always_comb begin
    in_full   = q_full(iw_q, ir_q);
    in_empty  = q_empty(iw_q, ir_q);
    out_full  = q_full(ow_q, or_q);
    out_empty = q_empty(ow_q, or_q);
    head      = imem[ir_q[AW-1:0]];
    head_info = head[PW-1 -: 8];
    head_cnt  = head[PW-9 -: 8];
    pkt_info  = core_pkt_q[PW-1 -: 8];
    pkt_cnt   = core_pkt_q[PW-9 -: 8];
    out_occ   = ow_q - or_q;
    // a packet anywhere between ISSUE and WRITE already owns an output slot
    credits   = (AW+2)'(DEPTH) - (AW+2)'(out_occ) - (AW+2)'(state_q != S_IDLE);
    issue_ok  = (state_q == S_IDLE) && !in_empty && (credits != '0);
  end

`ifdef SIMON_PKT_SEQCHK_EN
  logic [7:0] exp_q, exp_d;

  // a data packet at the head is rejected when its count is out of sequence
  always_comb begin
    seq_err = !head_info[5] && (head_cnt != exp_q);
  end

  // expected count steps on every data packet leaving the input queue
  always_comb begin
    exp_d = exp_q;
    if (issue_ok && seq_err) begin
      exp_d = exp_q + 8'd1;
    end else if ((state_q == S_ISSUE) && !pkt_info[5]) begin
      exp_d = exp_q + 8'd1;
    end
  end

  // expected-count register
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      exp_q <= 8'h01;
    end else begin
      exp_q <= exp_d;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

  // host capture side: armed-edge capture and input push
  always_comb begin
    in_push = in_newPKT && arm_q && !in_full;
    arm_d   = arm_q;
    if (!in_newPKT) begin
      arm_d = 1'b1;
    end else if (in_push) begin
      arm_d = 1'b0;
    end
    load_d = in_push;
    iw_d   = iw_q + (AW+1)'(in_push);
  end

  // core FSM: issue head to the core, collect its result into the output queue
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    core_pkt_d = core_pkt_q;
    res_d      = res_q;
    out_push   = 1'b0;
    out_word   = '0;
    wr_blk     = pkt_info[5] ? '0 : res_q;
    case (state_q)
      S_IDLE: begin
        if (issue_ok) begin
          if (seq_err) begin
            // out-of-sequence data bypasses the core and is flagged
            out_push = 1'b1;
            out_word = {head_info | 8'h80, head_cnt, {RW{1'b0}}};
            ir_d     = ir_q + 1'b1;
          end else begin
            core_pkt_d = head;
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        ir_d    = ir_q + 1'b1;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (core_done) begin
          res_d   = core_res;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        out_push = 1'b1;
        out_word = {pkt_info & 8'h7f, pkt_cnt, wr_blk};
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // host read side: rising edge of out_readPKT pops and locks until it drops
  always_comb begin
    rdp_d   = out_readPKT;
    out_pop = out_readPKT && !rdp_q && !out_empty;
    lock_d  = lock_q;
    if (out_pop) begin
      lock_d = 1'b1;
    end else if (!out_readPKT) begin
      lock_d = 1'b0;
    end
    ow_d = ow_q + (AW+1)'(out_push);
    or_d = or_q + (AW+1)'(out_pop);
  end

  // control registers and the core-facing packet register
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state_q    <= S_IDLE;
      iw_q       <= '0;
      ir_q       <= '0;
      ow_q       <= '0;
      or_q       <= '0;
      arm_q      <= 1'b0;
      load_q     <= 1'b0;
      lock_q     <= 1'b0;
      rdp_q      <= 1'b0;
      core_pkt_q <= '0;
    end else begin
      state_q    <= state_d;
      iw_q       <= iw_d;
      ir_q       <= ir_d;
      ow_q       <= ow_d;
      or_q       <= or_d;
      arm_q      <= arm_d;
      load_q     <= load_d;
      lock_q     <= lock_d;
      rdp_q      <= rdp_d;
      core_pkt_q <= core_pkt_d;
    end
  end

  // queue storage writes and the result holding register
  always_ff @(posedge clk) begin
    if (in_push) begin
      imem[iw_q[AW-1:0]] <= in;
    end
    if (out_push) begin
      omem[ow_q[AW-1:0]] <= out_word;
    end
    res_q <= res_d;
  end

  assign in_loadPKT  = load_q;
  assign in_donePKT  = (state_q == S_WRITE);
  assign core_go     = (state_q == S_ISSUE);
  assign core_pkt    = core_pkt_q;
  assign out_donePKT = !out_empty && !lock_q;
  assign out         = out_empty ? '0 : omem[or_q[AW-1:0]];

endmodule
